// File: rtl/l2_burst_adapter_if.sv
// Handshake bundle between the L2 line port and the 4-beat burst memory.
// slave : the adapter (responds on the line side, drives the burst side).
// master: the environment (L2 requester plus memory model).
interface l2_burst_adapter_if;
   logic [31:0]  line_address;
   logic [255:0] line_rdata;
   logic [255:0] line_wdata;
   logic         line_read;
   logic         line_write;
   logic         line_resp;
   logic [31:0]  burst_address;
   logic [63:0]  burst_rdata;
   logic [63:0]  burst_wdata;
   logic         burst_read;
   logic         burst_write;
   logic         burst_resp;

   modport slave (
      input  line_address, line_wdata, line_read, line_write,
      input  burst_rdata, burst_resp,
      output line_rdata, line_resp,
      output burst_address, burst_wdata, burst_read, burst_write
   );

   modport master (
      output line_address, line_wdata, line_read, line_write,
      output burst_rdata, burst_resp,
      input  line_rdata, line_resp,
      input  burst_address, burst_wdata, burst_read, burst_write
   );
endinterface

// File: rtl/l2_burst_adapter.sv
// L2 line (256b) to burst memory (4 x 64b) adapter.
// One burst per line request; writebacks are serialised into beats, read
// beats are assembled into line_rdata. Every output is a register.
module l2_burst_adapter (
   input  logic                clk,
   input  logic                rst,
   l2_burst_adapter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;

   state_t         r_state;
   logic [1:0]     r_beat;
   logic [255:0]   r_wdata;
   logic [255:0]   r_line_rdata;
   logic           r_line_resp;
   logic [31:0]    r_burst_address;
   logic [63:0]    r_burst_wdata;
   logic           r_burst_read;
   logic           r_burst_write;
   logic [1:0]     w_next_beat;

   assign w_next_beat       = r_beat + 2'd1;

   assign bus.line_rdata    = r_line_rdata;
   assign bus.line_resp     = r_line_resp;
   assign bus.burst_address = r_burst_address;
   assign bus.burst_wdata   = r_burst_wdata;
   assign bus.burst_read    = r_burst_read;
   assign bus.burst_write   = r_burst_write;

   // Request FSM with registered outputs; write wins over read in IDLE so a
   // pending writeback reaches memory before a read of the same line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= IDLE;
         r_beat          <= 2'd0;
         r_wdata         <= '0;
         r_line_rdata    <= '0;
         r_line_resp     <= 1'b0;
         r_burst_address <= '0;
         r_burst_wdata   <= '0;
         r_burst_read    <= 1'b0;
         r_burst_write   <= 1'b0;
      end else begin
         r_line_resp <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.line_write) begin
                  r_burst_address <= {bus.line_address[31:5], 5'b0};
                  r_wdata         <= bus.line_wdata;
                  r_burst_wdata   <= bus.line_wdata[63:0];
                  r_beat          <= 2'd0;
                  r_burst_write   <= 1'b1;
                  r_state         <= WR_BURST;
               end else if (bus.line_read) begin
                  r_burst_address <= {bus.line_address[31:5], 5'b0};
                  r_beat          <= 2'd0;
                  r_burst_read    <= 1'b1;
                  r_state         <= RD_BURST;
               end
            end
            RD_BURST: begin
               if (bus.burst_resp) begin
                  r_line_rdata[{r_beat, 6'b0} +: 64] <= bus.burst_rdata;
                  r_beat <= w_next_beat;
                  if (r_beat == 2'd3) begin
                     r_burst_read <= 1'b0;
                     r_line_resp  <= 1'b1;
                     r_state      <= RESP;
                  end
               end
            end
            WR_BURST: begin
               if (bus.burst_resp) begin
                  // present the next beat so it is on the bus the cycle after the ack
                  r_burst_wdata <= r_wdata[{w_next_beat, 6'b0} +: 64];
                  r_beat        <= w_next_beat;
                  if (r_beat == 2'd3) begin
                     r_burst_write <= 1'b0;
                     r_line_resp   <= 1'b1;
                     r_state       <= RESP;
                  end
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule
